// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU memory path: requester IDs, arbiter FSM states
// and default bus widths of the HPS FPGA-to-SDRAM port.
package gpu_mem_pkg;

    localparam int DEF_ADDR_W = 29;
    localparam int DEF_DATA_W = 64;

    typedef enum logic {
        REQ_SCANOUT = 1'b0,
        REQ_RASTER  = 1'b1
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_WBURST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rd_id_fifo.sv
// Small synchronous FIFO holding {requester id, burstcount} of issued reads.
// Head is visible combinationally so return beats can be routed in the same cycle.
module rd_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port between scanout (m0)
// and raster (m1); write bursts lock the grant, read IDs steer returned data.
module sdram_port_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = 8,
    parameter int BURST_W  = 8,
    parameter int MAX_PEND = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [ADDR_W-1:0]  m0_address,
    input  logic [BURST_W-1:0] m0_burstcount,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [DATA_W-1:0]  m0_writedata,
    input  logic [BE_W-1:0]    m0_byteenable,
    output logic               m0_waitrequest,
    output logic [DATA_W-1:0]  m0_readdata,
    output logic               m0_readdatavalid,

    input  logic [ADDR_W-1:0]  m1_address,
    input  logic [BURST_W-1:0] m1_burstcount,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [DATA_W-1:0]  m1_writedata,
    input  logic [BE_W-1:0]    m1_byteenable,
    output logic               m1_waitrequest,
    output logic [DATA_W-1:0]  m1_readdata,
    output logic               m1_readdatavalid,

    output logic [ADDR_W-1:0]  s_address,
    output logic [BURST_W-1:0] s_burstcount,
    output logic               s_read,
    output logic               s_write,
    output logic [DATA_W-1:0]  s_writedata,
    output logic [BE_W-1:0]    s_byteenable,
    input  logic               s_waitrequest,
    input  logic [DATA_W-1:0]  s_readdata,
    input  logic               s_readdatavalid,

    output logic               err_rdv
);

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    arb_state_e         state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BURST_W-1:0] ret_cnt_q, ret_cnt_d;
    logic               err_rdv_q, err_rdv_d;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BURST_W:0]   fifo_din, fifo_dout;
    logic               head_id;
    logic [BURST_W-1:0] head_bc;

    logic               g_read, g_write;
    logic [BURST_W-1:0] g_burstcount;
    logic               rd_room, elig0, elig1, rdv_hit;

    function automatic logic [BURST_W-1:0] eff_bc(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? ONE : bc;
    endfunction

    rd_id_fifo #(
        .DEPTH (MAX_PEND),
        .WIDTH (BURST_W + 1)
    ) u_rd_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_id = fifo_dout[BURST_W];
    assign head_bc = fifo_dout[BURST_W-1:0];

    // The command path is a pure mux on the registered grant.
    assign g_read       = grant_q ? m1_read       : m0_read;
    assign g_write      = grant_q ? m1_write      : m0_write;
    assign g_burstcount = grant_q ? m1_burstcount : m0_burstcount;
    assign s_address    = grant_q ? m1_address    : m0_address;
    assign s_burstcount = g_burstcount;
    assign s_writedata  = grant_q ? m1_writedata  : m0_writedata;
    assign s_byteenable = grant_q ? m1_byteenable : m0_byteenable;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign rdv_hit          = s_readdatavalid && !fifo_empty;
    assign m0_readdatavalid = rdv_hit && (head_id == REQ_SCANOUT);
    assign m1_readdatavalid = rdv_hit && (head_id == REQ_RASTER);
    assign err_rdv          = err_rdv_q;

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        fifo_pop  = 1'b0;
        if (rdv_hit) begin
            if (ret_cnt_q + ONE == eff_bc(head_bc)) begin
                fifo_pop  = 1'b1;
                ret_cnt_d = '0;
            end else begin
                ret_cnt_d = ret_cnt_q + ONE;
            end
        end
        err_rdv_d = err_rdv_q || (s_readdatavalid && fifo_empty);
    end

    // A slot freed by this cycle's final return beat is already usable.
    always_comb begin
        rd_room = !fifo_full || fifo_pop;
        elig0   = m0_read ? rd_room : m0_write;
        elig1   = m1_read ? rd_room : m1_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            ret_cnt_q    <= '0;
            err_rdv_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            err_rdv_q    <= err_rdv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        fifo_push    = 1'b0;
        fifo_din     = {grant_q, g_burstcount};
        unique case (state_q)
            ST_IDLE: begin
                if (elig0 || elig1) begin
                    grant_d      = (elig0 && elig1) ? !last_grant_q : elig1;
                    last_grant_d = grant_d;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (g_read) begin
                    if (!s_waitrequest) begin
                        fifo_push = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (g_write) begin
                    if (!s_waitrequest) begin
                        if (eff_bc(g_burstcount) == ONE) begin
                            state_d = ST_IDLE;
                        end else begin
                            beat_cnt_d = eff_bc(g_burstcount) - ONE;
                            state_d    = ST_WBURST;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WBURST: begin
                if (g_write && !s_waitrequest) begin
                    beat_cnt_d = beat_cnt_q - ONE;
                    if (beat_cnt_q == ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state_q)
            ST_GRANT, ST_WBURST: begin
                s_read  = (state_q == ST_GRANT) && g_read;
                s_write = g_write && !s_read && !((state_q == ST_GRANT) && g_read);
                if (grant_q) begin
                    m1_waitrequest = s_waitrequest;
                end else begin
                    m0_waitrequest = s_waitrequest;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: linear step sequence with
// hand-computed expectations checked by immediate assertions.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [28:0] m0_address, m1_address, s_address;
    logic [7:0]  m0_burstcount, m1_burstcount, s_burstcount;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata, s_writedata;
    logic [7:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [63:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        err_rdv;

    int total = 0;
    int bad   = 0;
    int beats;
    int wpat [12] = '{0, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_burstcount    (m0_burstcount),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_burstcount    (m1_burstcount),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_burstcount     (s_burstcount),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_rdv          (err_rdv)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_address = '0; m0_burstcount = '0; m0_read = 0; m0_write = 0;
        m0_writedata = '0; m0_byteenable = 8'hFF;
        m1_address = '0; m1_burstcount = '0; m1_read = 0; m1_write = 0;
        m1_writedata = '0; m1_byteenable = 8'hFF;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;

        cyc(); cyc(); settle();
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_err", err_rdv, 0);
        reset = 1'b0;
        cyc();

        $display("txn: m0 read addr=0x100 bc=4");
        m0_read = 1; m0_address = 29'h100; m0_burstcount = 4;
        settle();
        chk("t1_idle_s_read", s_read, 0);
        chk("t1_idle_m0_wait", m0_waitrequest, 1);
        cyc(); settle();
        chk("t1_s_read", s_read, 1);
        chk("t1_s_addr", s_address, 29'h100);
        chk("t1_s_bc", s_burstcount, 4);
        chk("t1_m0_wait", m0_waitrequest, 0);
        chk("t1_m1_wait", m1_waitrequest, 1);
        cyc(); m0_read = 0; settle();
        chk("t1_bubble", s_read, 0);
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1; s_readdata = 64'hD000 + 64'(i);
            settle();
            chk("t1_m0_rdv", m0_readdatavalid, 1);
            chk("t1_m1_rdv", m1_readdatavalid, 0);
            chk("t1_m0_rdata", m0_readdata, 64'hD000 + 64'(i));
            cyc();
        end
        s_readdatavalid = 0; settle();
        chk("t1_m0_rdv_end", m0_readdatavalid, 0);

        $display("txn: stray readdatavalid with fifo empty");
        s_readdatavalid = 1; settle();
        chk("t5_m0_rdv", m0_readdatavalid, 0);
        chk("t5_m1_rdv", m1_readdatavalid, 0);
        chk("t5_err_pre", err_rdv, 0);
        cyc(); s_readdatavalid = 0; settle();
        chk("t5_err_set", err_rdv, 1);
        cyc(); cyc(); settle();
        chk("t5_err_sticky", err_rdv, 1);

        $display("txn: m0 read + m1 8-beat write from reset");
        reset = 1;
        m0_read = 1; m0_address = 29'h200; m0_burstcount = 1;
        m1_write = 1; m1_address = 29'h300; m1_burstcount = 8; m1_writedata = 64'hA0;
        cyc(); settle();
        chk("t2_err_clr", err_rdv, 0);
        chk("t2_rst_s_read", s_read, 0);
        chk("t2_rst_s_write", s_write, 0);
        chk("t2_rst_m1_wait", m1_waitrequest, 1);
        reset = 0;
        cyc(); settle();
        chk("t2_g0_s_read", s_read, 1);
        chk("t2_g0_addr", s_address, 29'h200);
        chk("t2_g0_s_write", s_write, 0);
        chk("t2_g0_m0_wait", m0_waitrequest, 0);
        chk("t2_g0_m1_wait", m1_waitrequest, 1);
        cyc(); m0_read = 0; settle();
        chk("t2_bubble_r", s_read, 0);
        chk("t2_bubble_w", s_write, 0);
        cyc(); settle();
        chk("t2_g1_s_write", s_write, 1);
        chk("t2_g1_addr", s_address, 29'h300);
        chk("t2_g1_bc", s_burstcount, 8);
        chk("t2_g1_m0_wait", m0_waitrequest, 1);
        m0_read = 1; m0_address = 29'h400; m0_burstcount = 2;
        beats = 0;
        for (int k = 0; k < 12; k++) begin
            s_waitrequest = wpat[k][0];
            m1_writedata = 64'hA0 + 64'(beats);
            settle();
            chk("t2_burst_s_write", s_write, 1);
            chk("t2_burst_m1_wait", m1_waitrequest, wpat[k][0]);
            chk("t2_burst_m0_wait", m0_waitrequest, 1);
            chk("t2_burst_wdata", s_writedata, 64'hA0 + 64'(beats));
            if (wpat[k] == 0) beats++;
            cyc();
        end
        m1_write = 0; s_waitrequest = 0; settle();
        chk("t2_after8_s_write", s_write, 0);
        chk("t2_after8_s_read", s_read, 0);
        chk("t2_after8_m1_wait", m1_waitrequest, 1);
        cyc(); settle();
        chk("t2_m0_next_read", s_read, 1);
        chk("t2_m0_next_addr", s_address, 29'h400);
        chk("t2_m0_next_wait", m0_waitrequest, 0);
        cyc(); m0_read = 0;
        for (int i = 0; i < 3; i++) begin
            s_readdatavalid = 1; settle();
            chk("t2_drain_m0_rdv", m0_readdatavalid, 1);
            chk("t2_drain_m1_rdv", m1_readdatavalid, 0);
            cyc();
        end
        s_readdatavalid = 0;

        $display("txn: m0/m1 continuous reads bc=2");
        reset = 1; cyc(); reset = 0;
        m0_read = 1; m0_address = 29'h10; m0_burstcount = 2;
        m1_read = 1; m1_address = 29'h20; m1_burstcount = 2;
        settle();
        chk("t3_idle", s_read, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(); settle();
            chk("t3_s_read", s_read, 1);
            chk("t3_addr", s_address, (k % 2 == 1) ? 29'h20 : 29'h10);
            chk("t3_m0_wait", m0_waitrequest, (k % 2 == 1) ? 1 : 0);
            chk("t3_m1_wait", m1_waitrequest, (k % 2 == 1) ? 0 : 1);
            cyc(); settle();
            chk("t3_gap", s_read, 0);
        end
        m0_read = 0; m1_read = 0;
        for (int i = 0; i < 8; i++) begin
            s_readdatavalid = 1; s_readdata = 64'hB0 + 64'(i); settle();
            chk("t3_m0_rdv", m0_readdatavalid, ((i / 2) % 2 == 0) ? 1 : 0);
            chk("t3_m1_rdv", m1_readdatavalid, ((i / 2) % 2 == 1) ? 1 : 0);
            cyc();
        end
        s_readdatavalid = 0;

        $display("txn: four m1 reads outstanding then fifth stalls");
        m1_read = 1; m1_address = 29'h500; m1_burstcount = 1;
        for (int k = 0; k < 4; k++) begin
            cyc(); settle();
            chk("t4_s_read", s_read, 1);
            chk("t4_m1_wait", m1_waitrequest, 0);
            cyc(); settle();
            chk("t4_gap", s_read, 0);
        end
        m0_write = 1; m0_address = 29'h600; m0_burstcount = 0; m0_writedata = 64'h77;
        cyc(); settle();
        chk("t4_w_s_write", s_write, 1);
        chk("t4_w_s_read", s_read, 0);
        chk("t4_w_addr", s_address, 29'h600);
        chk("t4_w_wdata", s_writedata, 64'h77);
        chk("t4_w_m0_wait", m0_waitrequest, 0);
        chk("t4_w_m1_wait", m1_waitrequest, 1);
        cyc(); m0_write = 0; settle();
        chk("t4_w_done", s_write, 0);
        chk("t4_stall_a", m1_waitrequest, 1);
        cyc(); settle();
        chk("t4_stall_b_read", s_read, 0);
        chk("t4_stall_b_wait", m1_waitrequest, 1);
        s_readdatavalid = 1; settle();
        chk("t4_pop_m1_rdv", m1_readdatavalid, 1);
        chk("t4_pop_s_read", s_read, 0);
        cyc(); s_readdatavalid = 0; settle();
        chk("t4_fifth_s_read", s_read, 1);
        chk("t4_fifth_m1_wait", m1_waitrequest, 0);
        chk("t4_fifth_addr", s_address, 29'h500);
        cyc(); m1_read = 0; settle();
        chk("t4_fifth_done", s_read, 0);
        for (int i = 0; i < 4; i++) begin
            s_readdatavalid = 1; settle();
            chk("t4_drain_m1_rdv", m1_readdatavalid, 1);
            chk("t4_drain_m0_rdv", m0_readdatavalid, 0);
            cyc();
        end
        s_readdatavalid = 1; settle();
        chk("t4_empty_m1_rdv", m1_readdatavalid, 0);
        cyc(); s_readdatavalid = 0; settle();
        chk("t4_empty_err", err_rdv, 1);

        $display("txn: reset during beat 3 of 8-beat write");
        reset = 1; cyc(); reset = 0;
        m1_write = 1; m1_address = 29'h700; m1_burstcount = 8;
        cyc(); settle();
        chk("t6_s_write_b1", s_write, 1);
        cyc(); cyc(); settle();
        chk("t6_s_write_b3", s_write, 1);
        chk("t6_m1_wait_b3", m1_waitrequest, 0);
        reset = 1;
        cyc(); settle();
        chk("t6_rst_s_write", s_write, 0);
        chk("t6_rst_m0_wait", m0_waitrequest, 1);
        chk("t6_rst_m1_wait", m1_waitrequest, 1);
        chk("t6_rst_err", err_rdv, 0);
        reset = 0; m1_write = 0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
